// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - MIPS opcode constants for the memory instructions this stage handles
//   - FSM state encoding
//   - byte_lane(): big-endian byte extract (offset 0 = bits 31:24)
package mem_access_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] off);
        case (off)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// Combinational load-data formatter.
//   rdata     : full 32-bit word read from memory
//   offset    : byte offset within the word (big-endian)
//   is_signed : sign-extend the selected byte (LB) instead of zero-extend (LBU)
//   word      : pass the whole word through (LW)
//   result    : value handed to writeback
module load_formatter
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic        word,
    output logic [31:0] result
);

    logic [7:0] sel;
    assign sel = byte_lane(rdata, offset);

    always_comb begin
        result = rdata;
        if (!word) begin
            if (is_signed) result = {{24{sel[7]}}, sel};
            else           result = {24'h0, sel};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: holds one instruction from execute, performs
// LW/LB/LBU/SW/SB over a req/ack data-memory port and presents the result
// to writeback with a valid/ready handshake.
//   clock, reset                 : pipeline clock, synchronous active-high reset
//   in_valid/in_ready            : execute handshake (pc, insn, aluResult, rtData)
//   mem_req/we/addr/wdata/be     : memory request, held until ack or timeout
//   mem_ack/mem_rdata            : single-cycle completion from memory
//   out_valid/out_ready          : writeback handshake
//   out_pc/out_insn/dataOut      : result to writeback
//   misaligned/bus_err           : error qualifiers, meaningful only with out_valid
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc,
    input  logic [31:0] insn,
    input  logic [31:0] aluResult,
    input  logic [31:0] rtData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_insn,
    output logic [31:0] dataOut,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] r_alu;

    // Decode of the instruction being offered by execute.
    logic [5:0] in_op;
    logic       in_load, in_store, in_word, in_mis, accept;
    assign in_op    = insn[31:26];
    assign in_load  = (in_op == OP_LW) || (in_op == OP_LB) || (in_op == OP_LBU);
    assign in_store = (in_op == OP_SW) || (in_op == OP_SB);
    assign in_word  = (in_op == OP_LW) || (in_op == OP_SW);
    assign in_mis   = in_word && (aluResult[1:0] != 2'b00);

    // Retiring in OUT frees the stage in the same cycle.
    assign in_ready = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
    assign accept   = in_valid && in_ready;

    // Formatting of the in-flight load, driven from the latched instruction.
    logic [5:0]  r_op;
    logic [31:0] load_val;
    assign r_op = out_insn[31:26];

    load_formatter u_fmt (
        .rdata     (mem_rdata),
        .offset    (r_alu[1:0]),
        .is_signed (r_op == OP_LB),
        .word      (r_op == OP_LW),
        .result    (load_val)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            r_alu      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_insn   <= '0;
            dataOut    <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                ST_MEM: begin
                    // Ack on the final counted cycle takes priority over timeout.
                    if (mem_ack) begin
                        state     <= ST_OUT;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        dataOut   <= mem_we ? r_alu : load_val;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= ST_OUT;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        bus_err   <= 1'b1;
                        dataOut   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state      <= ST_IDLE;
                        out_valid  <= 1'b0;
                        misaligned <= 1'b0;
                        bus_err    <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Acceptance overrides the retire defaults above when handing off.
            if (accept) begin
                out_pc     <= pc;
                out_insn   <= insn;
                r_alu      <= aluResult;
                wait_cnt   <= '0;
                misaligned <= 1'b0;
                bus_err    <= 1'b0;
                if (!(in_load || in_store)) begin
                    state     <= ST_OUT;
                    out_valid <= 1'b1;
                    dataOut   <= aluResult;
                end else if (in_mis) begin
                    state      <= ST_OUT;
                    out_valid  <= 1'b1;
                    misaligned <= 1'b1;
                    dataOut    <= '0;
                end else begin
                    state     <= ST_MEM;
                    out_valid <= 1'b0;
                    mem_req   <= 1'b1;
                    mem_we    <= in_store;
                    mem_addr  <= {aluResult[31:2], 2'b00};
                    if (in_op == OP_SB) begin
                        mem_be    <= 4'b1000 >> aluResult[1:0];
                        mem_wdata <= {4{rtData[7:0]}};
                    end else begin
                        mem_be    <= 4'b1111;
                        mem_wdata <= rtData;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] pc, insn, aluResult, rtData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_insn, dataOut;
    logic        misaligned, bus_err;

    always #5 clock = ~clock;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .insn(insn), .aluResult(aluResult), .rtData(rtData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .dataOut(dataOut),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] data;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Memory responder: acks on the ack_at-th cycle of a request (0 = never),
    // records the request fields and how many cycles mem_req stayed high.
    int          ack_at = 0;
    logic [31:0] rd_val = '0;
    int          req_cyc = 0, last_len = 0, req_total = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cyc++;
                req_total++;
                if (req_cyc == 1) begin
                    cap_addr = mem_addr; cap_wdata = mem_wdata;
                    cap_be = mem_be; cap_we = mem_we;
                end
                if (req_cyc == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_val;
                end
            end else begin
                if (req_cyc > 0) last_len = req_cyc;
                req_cyc = 0;
            end
        end
    end

    // Monitor: compare every retired result against the scoreboard head.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got pc 0x%08h data 0x%08h, none expected", out_pc, dataOut);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_total++;
                if (out_pc === e.pc && out_insn === e.insn && dataOut === e.data &&
                    misaligned === e.mis && bus_err === e.berr)
                    n_pass++;
                else
                    $display("FAIL result pc=%08h: got insn %08h data %08h mis %0b berr %0b expected insn %08h data %08h mis %0b berr %0b",
                             e.pc, out_insn, dataOut, misaligned, bus_err, e.insn, e.data, e.mis, e.berr);
            end
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h0012345};
    endfunction

    // Present one instruction; returns just after the accepting edge.
    task automatic issue(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] r, input logic [31:0] d, input logic m, input logic b);
        exp_t e;
        bit   done = 0;
        e.pc = p; e.insn = i; e.data = d; e.mis = m; e.berr = b;
        exp_q.push_back(e);
        @(negedge clock);
        pc = p; insn = i; aluResult = a; rtData = r; in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            if (in_ready) done = 1;
            @(posedge clock);
            if (!done) @(negedge clock);
        end
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1 within 100 cycles");
        end
    endtask

    task automatic stop_issue();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int rt0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; insn = '0; aluResult = '0; rtData = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_errs", {misaligned, bus_err}, 0);
        @(negedge clock) reset = 1'b0;

        // ADD: result next cycle, no memory traffic
        rt0 = req_total;
        issue(32'h1000, mk(6'h00), 32'h0000_1234, 0, 32'h0000_1234, 0, 0);
        #1;
        chk("add_out_valid_next", out_valid, 1);
        chk("add_no_req", mem_req, 0);
        // back-to-back non-memory, one per cycle
        issue(32'h1004, mk(6'h08), 32'h0000_0001, 0, 32'h0000_0001, 0, 0);
        #1 chk("b2b_1_valid", out_valid, 1);
        issue(32'h1008, mk(6'h0D), 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 0);
        #1 chk("b2b_2_valid", out_valid, 1);
        stop_issue();
        drain();
        chk("nonmem_no_req", req_total, rt0);

        // LB 0x101, ack after 2 cycles
        ack_at = 2; rd_val = 32'h12F4_5678;
        issue(32'h2000, mk(6'b100000), 32'h101, 0, 32'hFFFF_FFF4, 0, 0);
        #1 chk("lb_in_ready_busy", in_ready, 0);
        stop_issue();
        drain();
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_be", cap_be, 4'b1111);
        chk("lb_we", cap_we, 0);
        chk("lb_req_len", last_len, 2);
        // LBU same
        issue(32'h2004, mk(6'b100100), 32'h101, 0, 32'h0000_00F4, 0, 0);
        stop_issue();
        drain();
        // LW aligned
        rd_val = 32'hDEAD_BEEF;
        issue(32'h2008, mk(6'b100011), 32'h200, 0, 32'hDEAD_BEEF, 0, 0);
        stop_issue();
        drain();

        // SB 0x203
        ack_at = 1;
        issue(32'h3000, mk(6'b101000), 32'h203, 32'hAABB_CC5A, 32'h203, 0, 0);
        stop_issue();
        drain();
        chk("sb_addr", cap_addr, 32'h200);
        chk("sb_be", cap_be, 4'b0001);
        chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        chk("sb_we", cap_we, 1);
        // SB offset 0
        issue(32'h3004, mk(6'b101000), 32'h204, 32'h0000_0077, 32'h204, 0, 0);
        stop_issue();
        drain();
        chk("sb0_be", cap_be, 4'b1000);
        chk("sb0_wdata", cap_wdata, 32'h7777_7777);
        // SW
        issue(32'h3008, mk(6'b101011), 32'h300, 32'h1122_3344, 32'h300, 0, 0);
        stop_issue();
        drain();
        chk("sw_be", cap_be, 4'b1111);
        chk("sw_wdata", cap_wdata, 32'h1122_3344);
        chk("sw_addr", cap_addr, 32'h300);

        // Misaligned LW: no request
        rt0 = req_total;
        issue(32'h4000, mk(6'b100011), 32'h102, 0, 32'h0, 1, 0);
        stop_issue();
        drain();
        chk("mis_no_req", req_total, rt0);

        // Timeout: mem_req high exactly 16 cycles, then bus_err
        ack_at = 0;
        issue(32'h5000, mk(6'b100011), 32'h400, 0, 32'h0, 0, 1);
        stop_issue();
        drain();
        chk("to_req_len", last_len, 16);
        // Ack on the 16th cycle wins
        ack_at = 16; rd_val = 32'h0BAD_F00D;
        issue(32'h5004, mk(6'b100011), 32'h404, 0, 32'h0BAD_F00D, 0, 0);
        stop_issue();
        drain();
        chk("ack16_req_len", last_len, 16);

        // Reset mid-request
        ack_at = 0;
        issue(32'h6000, mk(6'b100011), 32'h500, 0, 32'h0, 0, 0);
        stop_issue();
        repeat (3) @(negedge clock);
        chk("midreq_req_high", mem_req, 1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        chk("midreq_rst_req", mem_req, 0);
        chk("midreq_rst_valid", out_valid, 0);
        chk("midreq_rst_ready", in_ready, 1);
        @(negedge clock) reset = 1'b0;

        // Reset while stalled in OUT
        out_ready = 1'b0;
        issue(32'h7000, mk(6'h00), 32'h0000_ABCD, 0, 32'h0000_ABCD, 0, 0);
        stop_issue();
        repeat (3) @(negedge clock);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", dataOut, 32'h0000_ABCD);
        chk("stall_in_ready", in_ready, 0);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        chk("outrst_valid", out_valid, 0);
        chk("outrst_ready", in_ready, 1);
        chk("outrst_req", mem_req, 0);
        @(negedge clock) reset = 1'b0; out_ready = 1'b1;

        // Stage still usable after reset
        issue(32'h8000, mk(6'h00), 32'h0000_0042, 0, 32'h0000_0042, 0, 0);
        stop_issue();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage directly downstream of the execute-stage ALU in the MIPS pipeline. Consumes the ALU result (effective address or computed value) with the instruction word and rt data, performs LW/LB/LBU/SW/SB through a req/ack data-memory port, and hands load-formatted or passed-through results to writeback. It holds a single in-flight instruction and back-pressures execute while memory is busy.

## Interface
- TIMEOUT, 16: cycles to wait for mem_ack before aborting with bus_err; valid range 2..255.
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute result presented
- in_ready  out  1  stage can accept this cycle
- pc  in  32  instruction PC, passed through
- insn  in  32  instruction word; opcode = insn[31:26]
- aluResult  in  32  effective address for loads/stores, else the result
- rtData  in  32  store data
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {aluResult[31:2], 2'b00}
- mem_wdata  out  32  store data, byte-replicated for SB
- mem_be  out  4  byte enables; be[3] = bits 31:24
- mem_ack  in  1  single-cycle completion; mem_rdata valid same cycle
- mem_rdata  in  32  read data
- out_valid  out  1  result presented to writeback
- out_ready  in  1  writeback accepts
- out_pc, out_insn  out  32 each  passed-through copies
- dataOut  out  32  writeback value
- misaligned  out  1  qualifies out_valid: LW/SW with address[1:0] != 0
- bus_err  out  1  qualifies out_valid: memory timed out

## Operation
- Opcodes: LW 100011, LB 100000, LBU 100100, SW 101011, SB 101000; all other opcodes non-memory.
- Big-endian: byte offset 0 = bits 31:24, 3 = bits 7:0.
- FSM states IDLE, MEM, OUT. Reset: IDLE, all outputs 0, counters 0.
- IDLE: in_ready=1. On in_valid, latch pc/insn/aluResult/rtData. Non-memory → OUT, dataOut=aluResult. Misaligned LW/SW → OUT, misaligned=1, dataOut=0, no request. Otherwise → MEM.
- MEM: mem_req=1 with mem_we/addr/wdata/be constant. LW: be=1111. LB/LBU: be=1111 (full word read). SW: be=1111, wdata=rtData. SB: be one-hot by offset (off 0 → 1000, off 3 → 0001), wdata={4{rtData[7:0]}}.
- mem_ack in MEM → OUT next cycle, mem_req deasserts on that edge. Load dataOut: LW = rdata; LB = sign-extended selected byte; LBU = zero-extended. Stores: dataOut=aluResult.
- Wait counter starts at 0 on MEM entry, increments each cycle without ack; at TIMEOUT-1 with no ack → OUT, bus_err=1, dataOut=0. Ack on the last counted cycle wins over timeout.
- OUT: out_valid=1; outputs stable until out_ready. in_ready = (state==IDLE) or (state==OUT and out_ready): same-cycle handoff, next instruction latched on the retiring edge.
- No new acceptance while in MEM. mem_ack outside MEM is ignored.
- reset in any state, including mid-request: next edge IDLE, mem_req=0, out_valid=0, transaction discarded.

## Timing
- Non-memory / misaligned: accept edge N, out_valid from N+1.
- Memory: mem_req from N+1; ack in cycle N+k → out_valid from N+k+1.
- Back-to-back non-memory with out_ready=1: one result per cycle.
- Timeout: out_valid exactly TIMEOUT cycles after mem_req first rises.
- misaligned, bus_err, dataOut valid only while out_valid=1.

## Structure
- Shared package: opcode constants (LW, LB, LBU, SW, SB, RTYPE), FSM state encoding, byte-lane extract function.
- One sub-module: load_formatter (combinational; rdata, offset, signed → 32-bit result); stage and FSM in mem_access_stage.

## Test plan
- ADD insn, aluResult=0x0000_1234, out_ready=1 → out_valid next cycle, dataOut=0x1234, no mem_req.
- LB at 0x100, ack after 2 cycles with rdata=0x12_F4_56_78 at offset 1 (addr 0x101) → dataOut=0xFFFF_FFF4; LBU same → 0x0000_00F4.
- SB addr 0x203, rtData=0xAABBCC5A → mem_addr=0x200, be=0001, wdata=0x5A5A5A5A, mem_we=1.
- LW addr 0x102 → misaligned=1, dataOut=0, mem_req never asserted.
- LW with no ack, TIMEOUT=16 → mem_req high exactly 16 cycles, then out_valid with bus_err=1; ack on cycle 16 instead → normal completion.
- reset asserted during MEM with out_ready held low in OUT → next cycle IDLE, mem_req=0, out_valid=0, in_ready=1.
